// File: rtl/c64_mem_map.sv
// rtl/c64_mem_map.sv - C64 memory map, 6510 I/O port and CPU reset sequencer
`timescale 1ns/1ps
module c64_mem_map #(
    parameter int          RESET_HOLD  = 4,
    parameter logic [7:0]  PORT_PULLUP = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_reset,
    input  logic [15:0] ab,
    input  logic        we,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [12:0] basic_addr,
    input  logic [7:0]  basic_rdata,
    output logic [12:0] kernal_addr,
    input  logic [7:0]  kernal_rdata,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_rdata,
    output logic        io_cs,
    output logic        io_we,
    input  logic [7:0]  io_rdata,
    output logic [7:0]  port_out,
    input  logic [7:0]  port_in
);
    localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_HOLD - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic [2:0] {
        R_RAM, R_BASIC, R_KERNAL, R_CHAR, R_IO, R_PORT0, R_PORT1
    } region_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cpu_reset_q;
    logic [7:0]    ddr_q, port_q, port_rd_q;
    region_t       region_q, region_d;
    logic [7:0]    pins;
    logic          run;

    assign run      = (state_q == ST_RUN);
    assign pins     = (port_q & ddr_q) | ((port_in | PORT_PULLUP) & ~ddr_q);
    assign port_out = pins;
    assign cpu_reset = cpu_reset_q;

    assign ram_addr    = ab;
    assign ram_wdata   = dout;
    assign basic_addr  = ab[12:0];
    assign kernal_addr = ab[12:0];
    assign char_addr   = ab[11:0];

    // Reset sequencer: hold the core in reset for RESET_HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == CNT_LAST) state_d = ST_RUN;
            else                   cnt_d   = cnt_q + CW'(1);
        end
    end

    // Address decode against the LORAM/HIRAM/CHAREN banking lines
    always_comb begin
        region_d = R_RAM;
        if (ab == 16'h0000)      region_d = R_PORT0;
        else if (ab == 16'h0001) region_d = R_PORT1;
        else begin
            case (ab[15:12])
                4'hA, 4'hB: if (pins[0] && pins[1]) region_d = R_BASIC;
                4'hD:       if (pins[0] || pins[1]) region_d = pins[2] ? R_IO : R_CHAR;
                4'hE, 4'hF: if (pins[1]) region_d = R_KERNAL;
                default:    region_d = R_RAM;
            endcase
        end
    end

    // Bus strobes: nothing escapes while the core is held in reset
    always_comb begin
        io_cs  = run && (region_d == R_IO);
        io_we  = io_cs && we;
        ram_we = run && we && (region_d != R_IO);
    end

    // Sequencer, processor port and read-path registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            cpu_reset_q <= 1'b1;
            ddr_q       <= 8'h00;
            port_q      <= 8'h00;
            region_q    <= R_RAM;
            port_rd_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_reset_q <= (state_d == ST_INIT);
            region_q    <= run ? region_d : R_RAM;
            port_rd_q   <= run ? ((ab == 16'h0000) ? ddr_q : pins) : 8'h00;
            if (run && we && ab == 16'h0000) ddr_q  <= dout;
            if (run && we && ab == 16'h0001) port_q <= dout;
        end
    end

    // Read-data steering, one cycle behind the address
    always_comb begin
        di = 8'h00;
        if (run) begin
            case (region_q)
                R_RAM:            di = ram_rdata;
                R_BASIC:          di = basic_rdata;
                R_KERNAL:         di = kernal_rdata;
                R_CHAR:           di = char_rdata;
                R_IO:             di = io_rdata;
                R_PORT0, R_PORT1: di = port_rd_q;
                default:          di = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_c64_mem_map.sv
// tb/tb_c64_mem_map.sv - scoreboard bench for c64_mem_map with banking reference model
`timescale 1ns/1ps
module tb_c64_mem_map;
    localparam int         RESET_HOLD = 4;
    localparam logic [7:0] PULLUP     = 8'hFF;

    logic        clk, reset, cpu_reset, we, ram_we, io_cs, io_we;
    logic [15:0] ab, ram_addr;
    logic [7:0]  dout, di, ram_wdata, ram_rdata, basic_rdata, kernal_rdata;
    logic [7:0]  char_rdata, io_rdata, port_out, port_in;
    logic [12:0] basic_addr, kernal_addr;
    logic [11:0] char_addr;

    c64_mem_map #(.RESET_HOLD(RESET_HOLD), .PORT_PULLUP(PULLUP)) dut (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .ab(ab), .we(we),
        .dout(dout), .di(di), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .basic_addr(basic_addr),
        .basic_rdata(basic_rdata), .kernal_addr(kernal_addr),
        .kernal_rdata(kernal_rdata), .char_addr(char_addr),
        .char_rdata(char_rdata), .io_cs(io_cs), .io_we(io_we),
        .io_rdata(io_rdata), .port_out(port_out), .port_in(port_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] ram_pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] basic_fn(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h94;
    endfunction
    function automatic logic [7:0] kernal_fn(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h85;
    endfunction
    function automatic logic [7:0] char_fn(input logic [11:0] a);
        return a[7:0] ^ {4'b0000, a[11:8]} ^ 8'h3C;
    endfunction
    function automatic logic [7:0] io_fn(input logic [15:0] a);
        return a[7:0] + 8'h11;
    endfunction

    // Bench-side synchronous memories; RAM stores data XOR a pattern so a cleared array reads back the pattern
    logic [7:0] mem [0:65535];
    logic       mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata ^ ram_pat(ram_addr);
        end
        ram_rdata    <= mem[ram_addr] ^ ram_pat(ram_addr);
        basic_rdata  <= basic_fn(basic_addr);
        kernal_rdata <= kernal_fn(kernal_addr);
        char_rdata   <= char_fn(char_addr);
        io_rdata     <= io_fn(ram_addr);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] shadow [0:65535];
    logic [7:0] m_ddr, m_port;
    int         m_edges;
    bit         m_run;

    typedef struct {bit care; logic [7:0] exp; logic [15:0] a;} sb_t;
    sb_t sb [$];

    // Expected read value for address a given the effective port pins
    function automatic logic [7:0] model_read(input logic [15:0] a, input logic [7:0] p);
        bit lo = p[0], hi = p[1], ch = p[2];
        if (a == 16'h0000) return m_ddr;
        if (a == 16'h0001) return p;
        if (a >= 16'hA000 && a <= 16'hBFFF && lo && hi) return basic_fn(a[12:0]);
        if (a >= 16'hD000 && a <= 16'hDFFF && (lo || hi))
            return ch ? io_fn(a) : char_fn(a[11:0]);
        if (a >= 16'hE000 && hi) return kernal_fn(a[12:0]);
        return shadow[a];
    endfunction

    task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d, input logic rst);
        logic [7:0] p, rv;
        bit is_io, next_run;
        sb_t e;
        @(negedge clk);
        reset = rst; ab = a; we = w; dout = d; port_in = 8'($urandom);
        if (!rst) begin
            m_run = 0; m_edges = 0; m_ddr = 8'h00; m_port = 8'h00;
        end
        p = (m_port & m_ddr) | ((port_in | PULLUP) & ~m_ddr);
        is_io = m_run && a >= 16'hD000 && a <= 16'hDFFF && (p[0] || p[1]) && p[2];
        rv = model_read(a, p);
        #1;
        chk("cpu_reset", {15'd0, cpu_reset}, {15'd0, !m_run});
        chk("ram_we", {15'd0, ram_we}, {15'd0, m_run && w && !is_io});
        chk("io_cs", {15'd0, io_cs}, {15'd0, is_io});
        chk("io_we", {15'd0, io_we}, {15'd0, is_io && w});
        chk("port_out", {8'd0, port_out}, {8'd0, p});
        chk("ram_addr", ram_addr, a);
        @(posedge clk);
        if (m_run && w) begin
            if (!is_io) shadow[a] = d;
            if (a == 16'h0000) m_ddr = d;
            if (a == 16'h0001) m_port = d;
        end
        if (rst && m_edges < RESET_HOLD) m_edges++;
        next_run = rst && (m_edges >= RESET_HOLD);
        e.a = a;
        if (m_run) begin e.care = !w; e.exp = rv; end
        else begin e.care = !next_run; e.exp = 8'h00; end
        sb.push_back(e);
        m_run = next_run;
    endtask

    // Monitor: di for the cycle issued at an edge is sampled just after that edge
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.care) chk($sformatf("di@%h", e.a), {8'd0, di}, {8'd0, e.exp});
            end
        end
    end

    logic [15:0] bnd [9] = '{16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000, 16'hCFFF,
                             16'hD000, 16'hDFFF, 16'hE000, 16'hFFFF};

    initial begin
        logic [15:0] a;
        reset = 1'b0; ab = 16'h0; we = 1'b0; dout = 8'h0; port_in = 8'h0;
        m_ddr = 8'h00; m_port = 8'h00; m_edges = 0; m_run = 0;
        for (int i = 0; i < 65536; i++) shadow[i] = ram_pat(16'(i));
        @(posedge clk);
        #1 mem_clr = 1'b0;

        // Reset held for 3 cycles with writes attempted, then release
        for (int i = 0; i < 3; i++) cyc(16'h1234, 1'b1, 8'hEE, 1'b0);
        chk("port_out_reset", {8'd0, port_out}, 16'h00FF);
        for (int i = 0; i < 5; i++) cyc(16'h2000 + 16'(i), 1'b1, 8'h33, 1'b1);

        // Standard map reads
        cyc(16'hA000, 0, 0, 1); cyc(16'hE000, 0, 0, 1); cyc(16'hD000, 0, 0, 1);
        cyc(16'h2000, 0, 0, 1);

        // All-RAM map
        cyc(16'h0000, 1, 8'h07, 1); cyc(16'h0001, 1, 8'h00, 1);
        #1 chk("port_out_f8", {8'd0, port_out}, 16'h00F8);
        cyc(16'hA000, 0, 0, 1); cyc(16'hD000, 0, 0, 1); cyc(16'hE000, 0, 0, 1);
        cyc(16'h0001, 0, 0, 1); cyc(16'h0000, 0, 0, 1);

        // CHAR ROM visible, writes under it land in RAM
        cyc(16'h0001, 1, 8'h03, 1);
        cyc(16'hD800, 0, 0, 1); cyc(16'hD800, 1, 8'h55, 1); cyc(16'hD800, 0, 0, 1);
        cyc(16'hE123, 1, 8'hAA, 1); cyc(16'hE123, 0, 0, 1);
        cyc(16'h0001, 1, 8'h00, 1); cyc(16'hD800, 0, 0, 1); cyc(16'hE123, 0, 0, 1);
        cyc(16'h0001, 1, 8'h05, 1); cyc(16'h0001, 0, 0, 1);

        // Boundaries under every LORAM/HIRAM/CHAREN combination
        for (int c = 0; c < 8; c++) begin
            cyc(16'h0001, 1, 8'(c), 1);
            foreach (bnd[k]) cyc(bnd[k], 0, 0, 1);
        end

        // Mid-run reset with ddr=07
        cyc(16'h0001, 1, 8'h00, 1);
        cyc(16'h4000, 0, 0, 0);
        chk("port_out_midrst", {8'd0, port_out}, 16'h00FF);
        cyc(16'h4000, 1, 8'h99, 0);
        for (int i = 0; i < RESET_HOLD + 1; i++) cyc(16'hA000, 0, 0, 1);
        cyc(16'hE000, 0, 0, 1); cyc(16'hD000, 0, 0, 1); cyc(16'h0000, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 15);
            if (sel == 0)      a = 16'(($urandom_range(0, 3) == 0) ? 0 : 1);
            else if (sel < 7)  a = bnd[$urandom_range(0, 8)] + 16'($urandom_range(0, 1)) - 16'($urandom_range(0, 1));
            else               a = 16'($urandom);
            cyc(a, ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 499) != 0));
        end

        cyc(16'h0000, 0, 0, 1); cyc(16'h0000, 0, 0, 1);
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
